tsp_anneal_sched: RTL and testbench
===================================

# tsp_anneal_sched

Run controller for the TSP 2-opt/swap optimizer. It sequences the swap-evaluation datapath: waits for graph generation, issues one evaluation per iteration, decides acceptance under a decaying simulated-annealing threshold, commits accepted swaps, and terminates on an iteration budget, a stall limit or an abort. It sits between the top-level run logic and the pair-select/checkswap datapath, and owns all iteration and performance bookkeeping.

## Interface
- N_ITER, 100000: iteration budget; the run ends when iter_count reaches it.
- STALL_LIMIT, 4096: consecutive non-improving iterations that end the run.
- T0, 256: initial acceptance threshold, unsigned.
- EPOCH_LEN, 1024: iterations per threshold-decay step.
- DECAY_SHIFT, 3: threshold decay amount is threshold >> DECAY_SHIFT.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse that begins a run; honoured only in IDLE or DONE.
- abort  in  1  ends the run early; honoured in any state except IDLE.
- graph_ready  in  1  graph generation complete, level.
- eval_start  out  1  one-cycle pulse; the datapath picks a pair and evaluates it.
- eval_done  in  1  one-cycle pulse; eval_gain is valid.
- eval_gain  in  32  signed; old minus new tour length (>0 means improvement).
- commit  out  1  one-cycle pulse; the datapath applies the evaluated swap.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- iter_count  out  32  completed evaluations in the current run.
- accept_count  out  32  committed swaps in the current run.
- total_gain  out  32  signed sum of committed eval_gain values.
- threshold  out  32  current acceptance threshold.

## Operation
- States: IDLE, WAIT_GRAPH, ISSUE, WAIT_EVAL, COMMIT, DONE.
- IDLE: on start, clear all counters, load threshold=T0, go to WAIT_GRAPH.
- WAIT_GRAPH: when graph_ready=1, go to ISSUE.
- ISSUE: eval_start=1 for exactly this cycle, then go to WAIT_EVAL.
- WAIT_EVAL: wait for eval_done. When it arrives:
  - iter_count increments.
  - Accept when the 33-bit sign-extended sum eval_gain + threshold > 0. Gain equal to -threshold is rejected.
  - If accepted: accept_count increments, total_gain += eval_gain (32-bit wrap), next state COMMIT.
  - If rejected: go directly to the termination check.
- COMMIT: commit=1 for exactly this cycle, then the termination check.
- Stall counter (internal, saturating at STALL_LIMIT):
  - Cleared when eval_gain > 0.
  - Incremented otherwise, including on accepted non-improving swaps.
- Epoch counter (internal) increments per iteration. On reaching EPOCH_LEN it wraps to 0 and the threshold decays:
  - threshold -= threshold >> DECAY_SHIFT.
  - If that shift is 0 and threshold > 0, subtract 1 instead, so the threshold reaches 0 (pure greedy).
- Termination check, using post-update counters: iter_count==N_ITER or stall==STALL_LIMIT goes to DONE; otherwise go to ISSUE.
- DONE: outputs hold their final values. start begins a new run exactly as from IDLE.
- abort: next state DONE; commit is suppressed even if abort coincides with an accepting eval_done.
  - Counters still update for that eval_done.
  - abort beats start in the same cycle.
- eval_done outside WAIT_EVAL is ignored. start while busy is ignored.
- rst mid-run: state IDLE and all outputs at their reset values on the next cycle. No commit follows.

## Timing
- Reset values:
  - state IDLE.
  - eval_start, commit, busy, done all 0.
  - iter_count, accept_count, total_gain all 0.
  - threshold = T0.
- All outputs are registered.
- start to first eval_start: 2 cycles if graph_ready is already 1.
- Rejected iteration: 1 (ISSUE) + k cycles, where k ≥ 1 is the eval latency in cycles counted from entering WAIT_EVAL.
- Accepted iteration: 1 + k + 1 cycles.
- commit follows the accepting eval_done by exactly 1 cycle.
- Counter updates are visible on the cycle after eval_done.
- done rises 1 cycle after the final eval_done (rejected) or after COMMIT (accepted).

## Structure
- Package tsp_pkg holds the state enum (sched_state_t), GAIN_W=32 and the parameter defaults.
- Sub-module anneal_threshold holds the epoch counter and decay arithmetic.
  - Inputs: clk, rst, load, step.
  - Output: threshold.
  - tsp_anneal_sched drives load on run start and step on each eval_done.

## Test plan
- Reset then start, graph_ready held 0 for 10 cycles: no eval_start until graph_ready=1; first eval_start 1 cycle after it.
- N_ITER=8, datapath returns gain +5 after k=3 cycles: 8 commits, accept_count=8, total_gain=40, done=1, busy=0.
- T0=16, gains -15, -16, -17: accept, reject, reject; accept_count=1, total_gain=-15, commit exactly one cycle after the first eval_done only.
- EPOCH_LEN=4, DECAY_SHIFT=3, T0=16, all gains -100: threshold 16→14→13→12→11→10→9→8→7→6→5→4→3→2→1→0, then stays 0.
- STALL_LIMIT=5, gains 0 repeatedly with T0=1: run ends at iter_count=5; a positive gain at iteration 4 clears the stall and extends the run to iteration 9.
- abort asserted together with an accepting eval_done: no commit, DONE next cycle, iter_count incremented; rst mid-WAIT_EVAL returns all outputs to reset values.

Source files
------------

// File: rtl/tsp_pkg.sv
// Shared types and defaults for the TSP annealing run controller.
package tsp_pkg;

   localparam int GAIN_W = 32;

   localparam int unsigned N_ITER_DEF      = 100000;
   localparam int unsigned STALL_LIMIT_DEF = 4096;
   localparam int unsigned T0_DEF          = 256;
   localparam int unsigned EPOCH_LEN_DEF   = 1024;
   localparam int unsigned DECAY_SHIFT_DEF = 3;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_GRAPH,
      ISSUE,
      WAIT_EVAL,
      COMMIT,
      DONE
   } sched_state_t;

   // Amount to subtract at an epoch boundary; never stalls above zero.
   function automatic logic [GAIN_W-1:0] decay_amt(input logic [GAIN_W-1:0] thr,
                                                    input int unsigned       shift);
      logic [GAIN_W-1:0] d;
      d = thr >> shift;
      if (d == '0 && thr != '0) d = GAIN_W'(1);
      return d;
   endfunction

endpackage

// File: rtl/tsp_anneal_sched_threshold.sv
// Epoch counter and geometric threshold decay for the annealing schedule.
module anneal_threshold
   import tsp_pkg::*;
#(
   parameter int unsigned T0          = T0_DEF,
   parameter int unsigned EPOCH_LEN   = EPOCH_LEN_DEF,
   parameter int unsigned DECAY_SHIFT = DECAY_SHIFT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   output logic [GAIN_W-1:0] threshold
);

   localparam logic [31:0] EPOCH_LAST = 32'(EPOCH_LEN - 1);

   logic [31:0] epoch;

   always_ff @(posedge clk) begin
      if (rst || load) begin
         epoch     <= '0;
         threshold <= GAIN_W'(T0);
      end else if (step) begin
         if (epoch == EPOCH_LAST) begin
            epoch     <= '0;
            threshold <= threshold - decay_amt(threshold, DECAY_SHIFT);
         end else begin
            epoch <= epoch + 32'd1;
         end
      end
   end

endmodule

// File: rtl/tsp_anneal_sched.sv
// Run controller: issues swap evaluations, decides annealed acceptance, commits, terminates.
module tsp_anneal_sched
   import tsp_pkg::*;
#(
   parameter int unsigned N_ITER      = N_ITER_DEF,
   parameter int unsigned STALL_LIMIT = STALL_LIMIT_DEF,
   parameter int unsigned T0          = T0_DEF,
   parameter int unsigned EPOCH_LEN   = EPOCH_LEN_DEF,
   parameter int unsigned DECAY_SHIFT = DECAY_SHIFT_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     graph_ready,
   output logic                     eval_start,
   input  logic                     eval_done,
   input  logic signed [GAIN_W-1:0] eval_gain,
   output logic                     commit,
   output logic                     busy,
   output logic                     done,
   output logic [31:0]              iter_count,
   output logic [31:0]              accept_count,
   output logic signed [GAIN_W-1:0] total_gain,
   output logic [GAIN_W-1:0]        threshold
);

   localparam logic [31:0] N_ITER_C = 32'(N_ITER);
   localparam logic [31:0] STALL_C  = 32'(STALL_LIMIT);

   sched_state_t state;
   logic [31:0]  stall_cnt;

   logic                     run_start, eval_hit, accept, improve, stop_nxt, stop_now;
   logic [31:0]              iter_nxt, stall_nxt;
   logic signed [GAIN_W+1:0] sum;

   always_comb begin
      run_start = start && (state == IDLE || (state == DONE && !abort));
      eval_hit  = (state == WAIT_EVAL) && eval_done;
      // Two guard bits so gain + unsigned threshold can never overflow.
      sum       = $signed({{2{eval_gain[GAIN_W-1]}}, eval_gain}) + $signed({2'b00, threshold});
      accept    = (sum > 0);
      improve   = (eval_gain > 0);
      iter_nxt  = iter_count + 32'd1;
      stall_nxt = improve ? '0 : ((stall_cnt >= STALL_C) ? STALL_C : stall_cnt + 32'd1);
      stop_nxt  = (iter_nxt == N_ITER_C) || (stall_nxt == STALL_C);
      stop_now  = (iter_count == N_ITER_C) || (stall_cnt == STALL_C);
   end

   anneal_threshold #(
      .T0          (T0),
      .EPOCH_LEN   (EPOCH_LEN),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_thr (
      .clk       (clk),
      .rst       (rst),
      .load      (run_start),
      .step      (eval_hit),
      .threshold (threshold)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         eval_start   <= 1'b0;
         commit       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         iter_count   <= '0;
         accept_count <= '0;
         total_gain   <= '0;
         stall_cnt    <= '0;
      end else begin
         eval_start <= 1'b0;
         commit     <= 1'b0;

         // Counters track every eval_done in WAIT_EVAL, aborted or not.
         if (run_start) begin
            iter_count   <= '0;
            accept_count <= '0;
            total_gain   <= '0;
            stall_cnt    <= '0;
         end else if (eval_hit) begin
            iter_count <= iter_nxt;
            stall_cnt  <= stall_nxt;
            if (accept) begin
               accept_count <= accept_count + 32'd1;
               total_gain   <= total_gain + eval_gain;
            end
         end

         if (abort && state != IDLE) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     state <= WAIT_GRAPH;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
               WAIT_GRAPH: begin
                  if (graph_ready) begin
                     state      <= ISSUE;
                     eval_start <= 1'b1;
                  end
               end
               ISSUE: state <= WAIT_EVAL;
               WAIT_EVAL: begin
                  if (eval_done) begin
                     if (accept) begin
                        state  <= COMMIT;
                        commit <= 1'b1;
                     end else if (stop_nxt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state      <= ISSUE;
                        eval_start <= 1'b1;
                     end
                  end
               end
               COMMIT: begin
                  if (stop_now) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state      <= ISSUE;
                     eval_start <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tsp_anneal_sched.sv
// Randomized bench: acts as the swap datapath and checks against a run-level reference model.
module tb_tsp_anneal_sched;

   localparam int N_IT  = 80;
   localparam int STALL = 5;
   localparam int T0V   = 16;
   localparam int EPOCH = 4;
   localparam int DSH   = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0, abort = 1'b0, graph_ready = 1'b1;
   logic               eval_start, eval_done = 1'b0, commit, busy, done;
   logic signed [31:0] eval_gain = '0;
   logic [31:0]        iter_count, accept_count, threshold;
   logic signed [31:0] total_gain;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tsp_anneal_sched #(
      .N_ITER(N_IT), .STALL_LIMIT(STALL), .T0(T0V), .EPOCH_LEN(EPOCH), .DECAY_SHIFT(DSH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .graph_ready(graph_ready),
      .eval_start(eval_start), .eval_done(eval_done), .eval_gain(eval_gain),
      .commit(commit), .busy(busy), .done(done), .iter_count(iter_count),
      .accept_count(accept_count), .total_gain(total_gain), .threshold(threshold)
   );

   task automatic chk(input string tag, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // One full run; the bench is the datapath and the model follows the run rules.
   task automatic run(input int mode, input bit gwait);
      int     iter, nacc, stall, epoch, k, g;
      int     tot;
      longint thr, dec;
      bit     a, fin;
      iter = 0; nacc = 0; stall = 0; epoch = 0; tot = 0; thr = T0V; fin = 0;
      if (gwait) graph_ready = 1'b0;
      pulse_start();
      if (gwait) begin
         repeat (10) begin
            @(negedge clk); chk("gwait_no_eval", eval_start, 0);
            @(posedge clk); #1;
         end
         graph_ready = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      chk("first_eval_start", eval_start, 1);
      chk("run_busy", busy, 1);
      chk("run_iter0", iter_count, 0);
      chk("run_thr0", threshold, T0V);

      for (int n = 0; n < 200 && !fin; n++) begin
         // Stray eval_done / start during ISSUE must be ignored.
         if ($urandom_range(0, 3) == 0) begin
            eval_done = 1'b1; eval_gain = 32'(int'($urandom_range(0, 200)) - 100);
            start = 1'b1;
         end
         @(posedge clk); #1 eval_done = 1'b0; start = 1'b0;
         k = (mode == 0) ? 3 : int'($urandom_range(1, 4));
         repeat (k - 1) begin @(posedge clk); #1; end
         case (mode)
            0: g = 5;
            1: g = (iter < 3) ? -15 - iter : int'($urandom_range(0, 60)) - 30;
            2: g = (iter % 3 == 2) ? 1 : -100;
            3: g = 0;
            4: g = (iter == 3) ? 7 : 0;
            6: g = -int'(thr) + int'($urandom_range(0, 2)) - 1;
            default: g = int'($urandom_range(0, 80)) - 40;
         endcase
         eval_done = 1'b1; eval_gain = g;
         @(posedge clk); #1 eval_done = 1'b0;

         iter++;
         a = (longint'(g) + thr) > 0;
         if (a) begin nacc++; tot += g; end
         stall = (g > 0) ? 0 : ((stall < STALL) ? stall + 1 : STALL);
         epoch++;
         if (epoch == EPOCH) begin
            epoch = 0;
            dec = thr >> DSH;
            if (dec == 0 && thr > 0) dec = 1;
            thr -= dec;
         end
         fin = (iter == N_IT) || (stall == STALL);

         @(negedge clk);
         chk("commit", commit, a);
         chk("iter_count", iter_count, iter);
         chk("accept_count", accept_count, nacc);
         chk("total_gain", total_gain, tot);
         chk("threshold", threshold, thr);
         if (mode == 1 && iter == 3) begin
            chk("m1_acc3", accept_count, 1);
            chk("m1_tot3", total_gain, -15);
         end
         if (a) begin
            @(posedge clk); @(negedge clk);
            chk("commit_one_cycle", commit, 0);
         end
         chk("next_eval_start", eval_start, !fin);
         chk("done", done, fin);
         chk("busy", busy, !fin);
      end
      if (!fin) chk("run_bound", 0, 1);

      case (mode)
         0: begin
            chk("m0_acc", accept_count, N_IT);
            chk("m0_tot", total_gain, 5 * N_IT);
         end
         2: chk("m2_thr_floor", threshold, 0);
         3: chk("m3_stall_end", iter_count, 5);
         4: chk("m4_stall_end", iter_count, 9);
         default: ;
      endcase
      @(posedge clk); @(negedge clk);
      chk("done_hold_iter", iter_count, iter);
      chk("done_hold", done, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_eval_start", eval_start, 0);
      chk("rst_commit", commit, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_iter", iter_count, 0);
      chk("rst_acc", accept_count, 0);
      chk("rst_tot", total_gain, 0);
      chk("rst_thr", threshold, T0V);
      @(posedge clk); #1 rst = 1'b0;

      run(0, 1'b1);
      run(1, 1'b0);
      run(2, 1'b0);
      run(3, 1'b0);
      run(4, 1'b0);
      run(5, 1'b0);
      run(6, 1'b0);
      run(5, 1'b0);

      // abort together with an accepting eval_done
      pulse_start();
      @(posedge clk); @(negedge clk);
      chk("ab_eval_start", eval_start, 1);
      @(posedge clk); #1 eval_done = 1'b1; eval_gain = 5; abort = 1'b1;
      @(posedge clk); #1 eval_done = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("ab_commit", commit, 0);
      chk("ab_done", done, 1);
      chk("ab_busy", busy, 0);
      chk("ab_iter", iter_count, 1);
      chk("ab_acc", accept_count, 1);
      chk("ab_tot", total_gain, 5);
      @(posedge clk); @(negedge clk);
      chk("ab_commit_late", commit, 0);
      // abort beats start
      @(posedge clk); #1 start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("ab_vs_start_done", done, 1);
      chk("ab_vs_start_iter", iter_count, 1);

      // reset in WAIT_EVAL
      pulse_start();
      @(posedge clk); @(negedge clk);
      chk("rm_eval_start", eval_start, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rm_busy", busy, 0);
      chk("rm_done", done, 0);
      chk("rm_iter", iter_count, 0);
      chk("rm_thr", threshold, T0V);
      @(posedge clk); #1 eval_done = 1'b1; eval_gain = 5;
      @(posedge clk); #1 eval_done = 1'b0;
      @(negedge clk);
      chk("rm_no_commit", commit, 0);
      chk("rm_iter_after", iter_count, 0);
      chk("rm_acc_after", accept_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
